// File: rtl/gbif_req_sched.sv
// Scheduler for the shared GBIF/IFGB off-chip interface.
// Arbitrates eight typed requesters round-robin and issues the cfg word.
// Then it counts the fixed-length burst, steering read beats to the granted
// requester or write beats from it, and ends with a one-cycle done pulse.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no transfer; req sampled, winner picked and cfg word loaded
// S_CFG   | GBIF_cfg_val held with a stable cfg word until IFGB_cfg_rdy
// S_TRANS | data burst; beat_cnt advances on each beat handshake
// S_DONE  | one-cycle done pulse for the granted type, gnt still held
module gbif_req_sched #(
  parameter int PORT_WIDTH = 128,
  parameter int LEN_CFG    = 64,
  parameter int LEN_WR     = 64,
  parameter int LEN_WADDR  = 54,
  parameter int LEN_BLK    = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            req,
  output logic [7:0]            gnt,
  output logic [7:0]            done,
  output logic                  int_rd_val,
  input  logic [7:0]            int_rd_rdy,
  output logic [PORT_WIDTH-1:0] int_rd_data,
  input  logic [1:0]            int_wr_val,
  output logic [1:0]            int_wr_rdy,
  input  logic [PORT_WIDTH-1:0] int_wr_data_1,
  input  logic [PORT_WIDTH-1:0] int_wr_data_2,
  output logic                  GBIF_cfg_val,
  input  logic                  IFGB_cfg_rdy,
  output logic [3:0]            GBIF_cfg_info,
  output logic                  GBIF_wr_val,
  input  logic                  IFGB_wr_rdy,
  output logic [PORT_WIDTH-1:0] GBIF_wr_data,
  input  logic                  IFGB_rd_val,
  output logic                  GBIF_rd_rdy,
  input  logic [PORT_WIDTH-1:0] IFGB_rd_data
);

  typedef enum logic [1:0] {S_IDLE, S_CFG, S_TRANS, S_DONE} state_t;

  state_t     state, state_nxt;
  logic [2:0] typ;
  logic [2:0] rr_ptr;
  logic [2:0] win;
  logic       win_found;
  logic [9:0] beat_cnt;
  logic [9:0] len;
  logic [9:0] len_sel;
  logic       is_wr;
  logic       wr_sel;
  logic       beat_fire;
  logic       last_beat;

  // Types 1 and 2 are the only write transfers; type 2 uses writer slot 1.
  assign is_wr  = (typ == 3'd1) || (typ == 3'd2);
  assign wr_sel = typ[1];

  // Round-robin search starting one past the last grant.
  always_comb begin
    win       = rr_ptr;
    win_found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (!win_found && req[rr_ptr + 3'(i)]) begin
        win       = rr_ptr + 3'(i);
        win_found = 1'b1;
      end
    end
  end

  // Burst length for the granted type.
  always_comb begin
    len_sel = 10'(LEN_BLK);
    case (typ)
      3'd0:         len_sel = 10'(LEN_CFG);
      3'd1, 3'd2:   len_sel = 10'(LEN_WR);
      3'd3:         len_sel = 10'(LEN_WADDR);
      default:      len_sel = 10'(LEN_BLK);
    endcase
  end

  // Data-path steering; everything is quiet outside the burst.
  always_comb begin
    GBIF_rd_rdy  = 1'b0;
    int_rd_val   = 1'b0;
    int_rd_data  = '0;
    GBIF_wr_val  = 1'b0;
    GBIF_wr_data = '0;
    int_wr_rdy   = 2'b00;
    if (state == S_TRANS) begin
      if (is_wr) begin
        GBIF_wr_val        = int_wr_val[wr_sel];
        GBIF_wr_data       = wr_sel ? int_wr_data_2 : int_wr_data_1;
        int_wr_rdy[wr_sel] = IFGB_wr_rdy;
      end else begin
        GBIF_rd_rdy = int_rd_rdy[typ];
        int_rd_val  = IFGB_rd_val;
        int_rd_data = IFGB_rd_data;
      end
    end
  end

  assign beat_fire = (state == S_TRANS) &&
                     (is_wr ? (GBIF_wr_val && IFGB_wr_rdy) : (IFGB_rd_val && GBIF_rd_rdy));
  assign last_beat = beat_fire && (beat_cnt == len - 10'd1);

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|req)        state_nxt = S_CFG;
      S_CFG:   if (IFGB_cfg_rdy) state_nxt = S_TRANS;
      S_TRANS: if (last_beat)    state_nxt = S_DONE;
      S_DONE:                    state_nxt = S_IDLE;
      default:                   state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Grant, cfg word, beat counter and done pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt           <= '0;
      done          <= '0;
      GBIF_cfg_val  <= 1'b0;
      GBIF_cfg_info <= '0;
      typ           <= '0;
      rr_ptr        <= 3'd7;
      beat_cnt      <= '0;
      len           <= '0;
    end else begin
      done <= '0;
      case (state)
        S_IDLE: if (|req) begin
          gnt           <= 8'd1 << win;
          typ           <= win;
          GBIF_cfg_info <= {win, !((win == 3'd1) || (win == 3'd2))};
          GBIF_cfg_val  <= 1'b1;
          rr_ptr        <= win;
        end
        S_CFG: if (IFGB_cfg_rdy) begin
          GBIF_cfg_val <= 1'b0;
          beat_cnt     <= '0;
          len          <= len_sel;
        end
        S_TRANS: if (beat_fire) begin
          beat_cnt <= beat_cnt + 10'd1;
          if (last_beat) done <= 8'd1 << typ;
        end
        S_DONE: begin
          gnt           <= '0;
          GBIF_cfg_info <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gbif_req_sched.sv
// Scoreboard bench for gbif_req_sched: a reference model pushes expected
// cfg words, beat data and done events; a monitor pops and compares them.
module tb_gbif_req_sched;

  logic         clk;
  logic         rst;
  logic [7:0]   req;
  logic [7:0]   gnt;
  logic [7:0]   done;
  logic         int_rd_val;
  logic [7:0]   int_rd_rdy;
  logic [127:0] int_rd_data;
  logic [1:0]   int_wr_val;
  logic [1:0]   int_wr_rdy;
  logic [127:0] int_wr_data_1;
  logic [127:0] int_wr_data_2;
  logic         GBIF_cfg_val;
  logic         IFGB_cfg_rdy;
  logic [3:0]   GBIF_cfg_info;
  logic         GBIF_wr_val;
  logic         IFGB_wr_rdy;
  logic [127:0] GBIF_wr_data;
  logic         IFGB_rd_val;
  logic         GBIF_rd_rdy;
  logic [127:0] IFGB_rd_data;

  gbif_req_sched dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .done(done),
    .int_rd_val(int_rd_val), .int_rd_rdy(int_rd_rdy), .int_rd_data(int_rd_data),
    .int_wr_val(int_wr_val), .int_wr_rdy(int_wr_rdy),
    .int_wr_data_1(int_wr_data_1), .int_wr_data_2(int_wr_data_2),
    .GBIF_cfg_val(GBIF_cfg_val), .IFGB_cfg_rdy(IFGB_cfg_rdy), .GBIF_cfg_info(GBIF_cfg_info),
    .GBIF_wr_val(GBIF_wr_val), .IFGB_wr_rdy(IFGB_wr_rdy), .GBIF_wr_data(GBIF_wr_data),
    .IFGB_rd_val(IFGB_rd_val), .GBIF_rd_rdy(GBIF_rd_rdy), .IFGB_rd_data(IFGB_rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  bit rand_mode = 1'b0;
  bit full_rate = 1'b1;

  logic [3:0]   exp_cfg_info[$];
  logic [7:0]   exp_cfg_gnt[$];
  int           exp_cfg_hold[$];
  int           exp_done[$];
  logic [127:0] exp_rd[$];
  logic [127:0] exp_wr[$];

  int m_ptr  = 7;
  int m_ridx = 0;
  int m_w1   = 0;
  int m_w2   = 0;

  int beats_int = 0;
  int beats_gb  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic int len_of(input int t);
    case (t)
      0:       return 64;
      1, 2:    return 64;
      3:       return 54;
      default: return 512;
    endcase
  endfunction

  function automatic logic [127:0] rword(input int i);
    logic [31:0] v;
    v = i;
    return {v, ~v, v * 32'h9E3779B9, 32'hC0DE0000 + v};
  endfunction

  function automatic logic [127:0] wword(input int t, input int i);
    logic [31:0] v;
    logic [31:0] tt;
    v  = i;
    tt = t;
    return {32'hBEEF0000 + tt, v, ~v, v ^ 32'h5555AAAA};
  endfunction

  function automatic int rr_pick(input logic [7:0] p, input int ptr);
    for (int k = 1; k <= 8; k++)
      if (p[(ptr + k) % 8]) return (ptr + k) % 8;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [7:0] g);
    for (int i = 0; i < 8; i++)
      if (g[i]) return i;
    return 0;
  endfunction

  // Environment: requester/IFGB data sources advancing only on accepted beats.
  initial begin
    logic hs_r, hs_w1, hs_w2, clr;
    int   s_r, s_w1, s_w2;
    s_r = 0; s_w1 = 0; s_w2 = 0;
    IFGB_rd_val = 1'b0; int_rd_rdy = 8'h00; int_wr_val = 2'b00; IFGB_wr_rdy = 1'b0;
    IFGB_rd_data = rword(0); int_wr_data_1 = wword(1, 0); int_wr_data_2 = wword(2, 0);
    forever begin
      @(negedge clk);
      hs_r  = IFGB_rd_val && GBIF_rd_rdy;
      hs_w1 = int_wr_val[0] && int_wr_rdy[0];
      hs_w2 = int_wr_val[1] && int_wr_rdy[1];
      clr   = rst;
      @(posedge clk);
      #1;
      if (clr) begin
        s_r = 0; s_w1 = 0; s_w2 = 0;
      end else begin
        if (hs_r)  s_r++;
        if (hs_w1) s_w1++;
        if (hs_w2) s_w2++;
      end
      IFGB_rd_data  = rword(s_r);
      int_wr_data_1 = wword(1, s_w1);
      int_wr_data_2 = wword(2, s_w2);
      if (rand_mode) begin
        IFGB_rd_val = 1'($urandom_range(0, 1));
        int_rd_rdy  = 8'($urandom);
        int_wr_val  = 2'($urandom);
        IFGB_wr_rdy = 1'($urandom_range(0, 1));
      end else begin
        IFGB_rd_val = 1'b1;
        int_rd_rdy  = 8'hFF;
        int_wr_val  = 2'b11;
        IFGB_wr_rdy = 1'b1;
      end
    end
  end

  // Monitor: pops expected events whenever the DUT presents them.
  initial begin
    int   cyc, cfg_hold, cfg_hs_cyc, last_beat_cyc, gi, w;
    bit   prev_cfg_val, gb_hs;
    logic [3:0] prev_info;
    logic [7:0] prev_done;
    cyc = 0; cfg_hold = 0; cfg_hs_cyc = 0; last_beat_cyc = -10;
    prev_cfg_val = 1'b0; prev_info = '0; prev_done = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        beats_int = 0; beats_gb = 0; cfg_hold = 0;
        prev_cfg_val = 1'b0; prev_done = '0;
        continue;
      end
      gi = onehot_idx(gnt);
      chk("gnt_onehot", 128'($onehot0(gnt)), 1);
      chk("wr_rdy_nongranted", 128'(int_wr_rdy & ~{gnt[2], gnt[1]}), 0);
      chk("rd_val_nongranted", 128'(int_rd_val && ((gnt & 8'hF9) == 8'h00)), 0);

      if (GBIF_cfg_val) begin
        cfg_hold++;
        if (prev_cfg_val) chk("cfg_info_stable", 128'(GBIF_cfg_info), 128'(prev_info));
        if (IFGB_cfg_rdy) begin
          if (exp_cfg_info.size() == 0) chk("cfg_unexpected", 1, 0);
          else begin
            chk("cfg_info", 128'(GBIF_cfg_info), 128'(exp_cfg_info.pop_front()));
            chk("cfg_gnt", 128'(gnt), 128'(exp_cfg_gnt.pop_front()));
            chk("cfg_hold", 128'(cfg_hold), 128'(exp_cfg_hold.pop_front()));
          end
          cfg_hs_cyc = cyc; cfg_hold = 0; beats_int = 0; beats_gb = 0;
        end
      end
      prev_cfg_val = GBIF_cfg_val && !IFGB_cfg_rdy;
      prev_info    = GBIF_cfg_info;

      gb_hs = 1'b0;
      if (int_rd_val && int_rd_rdy[gi] && gnt != 8'h00) begin
        beats_int++;
        if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_data", int_rd_data, exp_rd.pop_front());
      end
      if (IFGB_rd_val && GBIF_rd_rdy) begin
        beats_gb++; gb_hs = 1'b1;
      end
      if ((int_wr_val & int_wr_rdy) != 2'b00) beats_int++;
      if (GBIF_wr_val && IFGB_wr_rdy) begin
        beats_gb++; gb_hs = 1'b1;
        if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
        else chk("wr_data", GBIF_wr_data, exp_wr.pop_front());
      end
      if (gb_hs && beats_gb == len_of(gi)) last_beat_cyc = cyc;

      if (done != 8'h00) begin
        chk("done_single", 128'(prev_done), 0);
        if (exp_done.size() == 0) chk("done_unexpected", 128'(done), 0);
        else begin
          w = exp_done.pop_front();
          chk("done_type", 128'(done), 128'(8'd1 << w));
          chk("done_gnt", 128'(gnt), 128'(8'd1 << w));
          chk("beats_int", 128'(beats_int), 128'(len_of(w)));
          chk("beats_gb", 128'(beats_gb), 128'(len_of(w)));
          chk("done_latency", 128'(cyc - last_beat_cyc), 1);
          chk("done_dp_quiet", 128'({GBIF_rd_rdy, int_rd_val, GBIF_wr_val, int_wr_rdy}), 0);
          if (full_rate) chk("txn_cycles", 128'(cyc - cfg_hs_cyc), 128'(len_of(w) + 1));
        end
      end
      prev_done = done;
    end
  end

  // Reference model: expand a request mask into the round-robin grant sequence.
  task automatic issue(input logic [7:0] r, input int hold);
    logic [7:0] pend;
    int w, h;
    pend = r; h = hold;
    while (pend != 8'h00) begin
      w = rr_pick(pend, m_ptr);
      exp_cfg_info.push_back({w[2:0], !(w == 1 || w == 2)});
      exp_cfg_gnt.push_back(8'd1 << w);
      exp_cfg_hold.push_back(h);
      h = 1;
      exp_done.push_back(w);
      for (int k = 0; k < len_of(w); k++) begin
        if (w == 1)      begin exp_wr.push_back(wword(1, m_w1)); m_w1++; end
        else if (w == 2) begin exp_wr.push_back(wword(2, m_w2)); m_w2++; end
        else             begin exp_rd.push_back(rword(m_ridx)); m_ridx++; end
      end
      m_ptr = w;
      pend[w] = 1'b0;
    end
    req = req | r;
  endtask

  // Requesters drop req at the edge ending their done cycle.
  task automatic wait_done(input int budget);
    logic [7:0] dn;
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      dn = done;
      @(posedge clk);
      #1;
      req = req & ~dn;
      if (dn != 8'h00 && exp_done.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("wait_done_timeout", 1, 0);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_gnt"}, 128'(gnt), 0);
    chk({nm, "_done"}, 128'(done), 0);
    chk({nm, "_cfg_val"}, 128'(GBIF_cfg_val), 0);
    chk({nm, "_cfg_info"}, 128'(GBIF_cfg_info), 0);
    chk({nm, "_dp_ctl"}, 128'({GBIF_rd_rdy, int_rd_val, GBIF_wr_val, int_wr_rdy}), 0);
    chk({nm, "_rd_data"}, int_rd_data, 0);
    chk({nm, "_wr_data"}, GBIF_wr_data, 0);
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = 8'h00;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_zero(nm);
    exp_cfg_info.delete(); exp_cfg_gnt.delete(); exp_cfg_hold.delete();
    exp_done.delete(); exp_rd.delete(); exp_wr.delete();
    m_ptr = 7; m_ridx = 0; m_w1 = 0; m_w2 = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bit hit;
    rst = 1'b1;
    req = 8'h00;
    IFGB_cfg_rdy = 1'b1;
    repeat (2) @(posedge clk);
    do_reset("rst0");

    // Full-rate type 0 read, with explicit req-to-cfg latency.
    rand_mode = 1'b0; full_rate = 1'b1;
    issue(8'h01, 1);
    @(negedge clk);
    chk("cfg_val_before", 128'(GBIF_cfg_val), 0);
    @(negedge clk);
    chk("cfg_val_t1", 128'(GBIF_cfg_val), 1);
    chk("cfg_info_t1", 128'(GBIF_cfg_info), 128'(4'b0001));
    wait_done(2000);

    // Type 3 read with random stalls on both sides.
    rand_mode = 1'b1; full_rate = 1'b0;
    issue(8'h08, 1);
    wait_done(4000);

    // Type 1 write with cfg ready held off for five cycles.
    IFGB_cfg_rdy = 1'b0;
    issue(8'h02, 6);
    hit = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (GBIF_cfg_val) begin hit = 1'b1; break; end
    end
    if (!hit) chk("cfg_val_timeout", 1, 0);
    repeat (5) @(posedge clk);
    #1;
    IFGB_cfg_rdy = 1'b1;
    wait_done(4000);

    // All eight requesters from reset, full rate.
    do_reset("rst1");
    rand_mode = 1'b0; full_rate = 1'b1;
    issue(8'hFF, 1);
    wait_done(6000);

    // Round-robin pointer after a type-4 grant.
    rand_mode = 1'b1; full_rate = 1'b0;
    issue(8'h10, 1);
    wait_done(8000);
    issue(8'h30, 1);
    wait_done(16000);

    // Reset in the middle of a type-6 burst, then a clean restart.
    rand_mode = 1'b0; full_rate = 1'b1;
    issue(8'h40, 1);
    hit = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      #1;
      if (beats_int == 100) begin hit = 1'b1; break; end
    end
    if (!hit) chk("beat100_timeout", 1, 0);
    do_reset("rst_mid");
    issue(8'h40, 1);
    wait_done(2000);

    repeat (3) @(posedge clk);
    chk("queues_drained", 128'(exp_cfg_info.size() + exp_done.size() + exp_rd.size() + exp_wr.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gbif_req_sched.md
# gbif_req_sched

Chip-side scheduler for the shared global-buffer off-chip interface (GBIF/IFGB). It arbitrates among eight internal requesters, one per transfer type, and issues the 4-bit configuration word over the cfg handshake. It then counts the fixed-length data burst, routing read beats to the granted requester or write beats from it, and signals completion. The block sits between the GB/CCU request logic and the chip-level GBIF_*/IFGB_* ports.

## Interface
- PORT_WIDTH, 128, width of the GBIF data words.
- LEN_CFG, 64, beats for type 0 (config read).
- LEN_WR, 64, beats for types 1 and 2 (output writes).
- LEN_WADDR, 54, beats for type 3 (weight address read).
- LEN_BLK, 512, beats for types 4–7 (weight data/flag, activation data/flag reads).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  8  request per type; bit i is type i.
- gnt  out  8  one-hot grant; held from CFG through DONE.
- done  out  8  one-cycle one-hot completion pulse.
- int_rd_val  out  1  read beat valid to the granted requester.
- int_rd_rdy  in  8  per-requester read ready.
- int_rd_data  out  PORT_WIDTH  read beat data.
- int_wr_val  in  2  write valid; bit 0 is type 1, bit 1 is type 2.
- int_wr_rdy  out  2  write ready back to the writers.
- int_wr_data_1 / int_wr_data_2  in  PORT_WIDTH each  write data for types 1 and 2.
- GBIF_cfg_val  out  1  cfg word valid.
- IFGB_cfg_rdy  in  1  cfg ready.
- GBIF_cfg_info  out  4  [3:1] = type, [0] = 1 for read, 0 for write.
- GBIF_wr_val  out  1  write valid.
- IFGB_wr_rdy  in  1  write ready.
- GBIF_wr_data  out  PORT_WIDTH  write data.
- IFGB_rd_val  in  1  read valid.
- GBIF_rd_rdy  out  1  read ready.
- IFGB_rd_data  in  PORT_WIDTH  read data.

## Operation
- States: IDLE, CFG, TRANS, DONE.
- IDLE:
  - If req != 0, pick the winner round-robin, searching from (last_grant+1) mod 8.
  - Register gnt, the type and GBIF_cfg_info = {type, type∉{1,2}}.
  - Assert GBIF_cfg_val; go to CFG.
  - The round-robin pointer updates to the winner at grant.
- CFG:
  - Hold GBIF_cfg_val=1 and GBIF_cfg_info stable until IFGB_cfg_rdy=1.
  - On handshake, drop GBIF_cfg_val, clear beat_cnt, load len from the type; go to TRANS.
- TRANS, read type (0, 3–7):
  - GBIF_rd_rdy = int_rd_rdy[type].
  - int_rd_val = IFGB_rd_val.
  - int_rd_data = IFGB_rd_data (combinational).
- TRANS, write type (1, 2):
  - GBIF_wr_val = int_wr_val[type-1].
  - GBIF_wr_data = selected int_wr_data_x.
  - int_wr_rdy[type-1] = IFGB_wr_rdy.
- Each beat handshake increments the 10-bit beat_cnt.
- A handshake with beat_cnt == len-1 is the last beat: go to DONE.
- DONE: pulse done[type]=1 for one cycle, then return to IDLE. gnt clears on entering IDLE.
- Outside TRANS, all data-path valids/readies are 0 (GBIF_rd_rdy, GBIF_wr_val, int_rd_val, int_wr_rdy). Non-granted requesters always see 0.
- Requesters drop req at the edge ending DONE. req is sampled only in IDLE; changes in other states are ignored.
- beat_cnt never wraps. The last beat always exits TRANS, and extra IFGB_rd_val beats after it are not accepted.
- rst in any state forces:
  - state IDLE, gnt=0, done=0, GBIF_cfg_val=0, GBIF_cfg_info=0;
  - beat_cnt=0, round-robin pointer=7, so type 0 wins first.
  - An in-flight burst is abandoned without a done pulse.

## Timing
- Reset values of all registered outputs are 0. Combinational data-path outputs are 0 because state is IDLE.
- req seen in IDLE at cycle t gives GBIF_cfg_val=1 and gnt valid at t+1.
- cfg handshake at cycle c gives TRANS at c+1. The first beat can complete in c+1.
- Zero-bubble bursts: a burst of N beats with continuous handshakes occupies exactly N TRANS cycles.
- Last beat at cycle e gives done at e+1 (DONE) and IDLE at e+2. The earliest next GBIF_cfg_val is e+3.
- Minimum non-stalled transaction: 1 + 1 + N + 1 cycles (IDLE + CFG + N beats + DONE).
- Stalls: a low ready/valid on either side stalls the beat indefinitely; beat_cnt holds.

## Test plan
- Reset then req=8'h01, IFGB_cfg_rdy and IFGB_rd_val always 1, int_rd_rdy[0]=1 -> cfg_info=4'b0001 one cycle after req; exactly 64 int_rd_val beats; done[0] at last beat+1.
- req=8'h08 with random IFGB_rd_val and int_rd_rdy[3] -> cfg_info=4'b0111; exactly 54 accepted beats, data passed unchanged in order; done[3] single pulse; GBIF_rd_rdy=0 after the last beat even if IFGB_rd_val stays high.
- req=8'h02, IFGB_cfg_rdy delayed 5 cycles -> cfg_info=4'b0010 held stable for 6 cycles; 64 write beats from int_wr_data_1; int_wr_rdy[1] and int_rd_val stay 0.
- req=8'hFF held, each requester drops req on its done -> grant order 0,1,2,…,7 with cycle lengths 64,64,64,54,512,512,512,512; gnt always one-hot.
- After a type-4 grant, req[4] reasserted with req[5] -> type 5 granted before type 4 (round-robin pointer respected).
- rst asserted mid-TRANS of type 6 at beat 100 -> next cycle all outputs 0, no done; next req=8'h40 restarts with a full 512-beat count.
